// File: rtl/sram_wb_emulator_pkg.sv
// Shared bus widths and FSM encoding for the SRAM-emulating Wishbone responder.
package sram_wb_emulator_pkg;

    localparam int unsigned WB_DAT_W  = 16;
    localparam int unsigned WB_SEL_W  = 2;
    localparam int unsigned WB_ADR_HI = 19;
    localparam int unsigned WB_ADR_LO = 1;

    // Wait-state counter covers the 0..15 range of WAIT_STATES.
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/sram_emu_mem.sv
// Two byte-wide on-chip RAM banks with per-lane write enables and a registered read port.
module sram_emu_mem
    import sram_wb_emulator_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DEPTH_LOG2-1:0] adr_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [WB_SEL_W-1:0]   wr_sel_i,
    input  logic [WB_DAT_W-1:0]   wr_dat_i,
    output logic [WB_DAT_W-1:0]   rd_dat_o
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic [7:0]          mem_lo_q [Depth];
    logic [7:0]          mem_hi_q [Depth];
    logic [WB_DAT_W-1:0] rd_dat_q;

    // Lane writes; the arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_sel_i[0]) begin
            mem_lo_q[adr_i] <= wr_dat_i[7:0];
        end
        if (wr_en_i && wr_sel_i[1]) begin
            mem_hi_q[adr_i] <= wr_dat_i[15:8];
        end
    end

    // Synchronous read; the output register holds until the next read.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= {mem_hi_q[adr_i], mem_lo_q[adr_i]};
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/sram_wb_emulator.sv
// Wishbone B4 pipelined responder backed by on-chip RAM with programmable wait states.
module sram_wb_emulator
    import sram_wb_emulator_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cyc_i,
    input  logic                       stb_i,
    input  logic                       we_i,
    input  logic [WB_SEL_W-1:0]        sel_i,
    input  logic [WB_ADR_HI:WB_ADR_LO] adr_i,
    input  logic [WB_DAT_W-1:0]        dat_i,
    output logic                       ack_o,
    output logic [WB_DAT_W-1:0]        dat_o,
    output logic                       stall_o
);

    localparam logic [WAIT_CNT_W-1:0] WaitInit = WAIT_CNT_W'(WAIT_STATES);
    localparam bit ZeroWait  = (WAIT_STATES == 0);
    localparam bit ShortWait = (WAIT_STATES <= 1);

    wb_state_e                 state_q;
    logic [WAIT_CNT_W-1:0]     cnt_q;
    logic                      ack_q;
    logic                      stall_q;
    logic                      we_q;
    logic [WB_SEL_W-1:0]       sel_q;
    logic [DEPTH_LOG2-1:0]     adr_q;
    logic [WB_DAT_W-1:0]       wdat_q;
    logic [WB_DAT_W-1:0]       rdat_q;

    logic                      accept;
    logic                      go_ack;
    logic                      rd_issue;
    logic                      ld_rdat;
    logic [DEPTH_LOG2-1:0]     mem_adr;
    logic                      mem_we;
    logic [WB_SEL_W-1:0]       mem_sel;
    logic [WB_DAT_W-1:0]       mem_wdat;
    logic [WB_DAT_W-1:0]       mem_rdat;

    // Address bits above the RAM depth alias and are deliberately dropped.
    logic unused_adr_hi;
    assign unused_adr_hi = ^adr_i[WB_ADR_HI:DEPTH_LOG2+1];

    // Memory port control: a request bypasses its own latch on the accepting edge.
    always_comb begin
        accept   = cyc_i & stb_i & ~stall_q;
        go_ack   = ZeroWait ? accept
                            : ((state_q == StWait) && cyc_i && (cnt_q == WAIT_CNT_W'(1)));
        mem_adr  = accept ? adr_i[DEPTH_LOG2:WB_ADR_LO] : adr_q;
        mem_sel  = accept ? sel_i : sel_q;
        mem_wdat = accept ? dat_i : wdat_q;
        mem_we   = go_ack & (accept ? we_i : we_q);
        // Read lands in the RAM output register one cycle before ack (or with it at 0 waits).
        if (ShortWait) begin
            rd_issue = accept & ~we_i;
        end else begin
            rd_issue = (state_q == StWait) && cyc_i && (cnt_q == WAIT_CNT_W'(2)) && !we_q;
        end
        ld_rdat  = !ZeroWait && go_ack && !we_q;
    end

    // Request FSM with registered ack/stall and the request latch.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
        end else begin
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            if (accept) begin
                we_q   <= we_i;
                sel_q  <= sel_i;
                adr_q  <= adr_i[DEPTH_LOG2:WB_ADR_LO];
                wdat_q <= dat_i;
            end
            case (state_q)
                StIdle, StAck: begin
                    if (accept) begin
                        if (ZeroWait) begin
                            state_q <= StAck;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            stall_q <= 1'b1;
                            cnt_q   <= WaitInit;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (!cyc_i) begin
                        // Initiator abandoned the cycle: drop the request without ack.
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == WAIT_CNT_W'(1)) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q - WAIT_CNT_W'(1);
                        stall_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Read data register, loaded on entry to ACK so dat_o holds outside ACK.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdat_q <= '0;
        end else if (ld_rdat) begin
            rdat_q <= mem_rdat;
        end
    end

    sram_emu_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .adr_i    (mem_adr),
        .rd_en_i  (rd_issue),
        .wr_en_i  (mem_we),
        .wr_sel_i (mem_sel),
        .wr_dat_i (mem_wdat),
        .rd_dat_o (mem_rdat)
    );

    // With no wait states the RAM output register is itself the data output.
    assign dat_o   = ZeroWait ? mem_rdat : rdat_q;
    assign ack_o   = ack_q;
    assign stall_o = stall_q;

endmodule

// File: tb/tb_sram_wb_emulator.sv
// Directed bench: four responders with different wait-state counts share one bus.
module tb_sram_wb_emulator;

    typedef struct {
        bit          rd;
        logic [15:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [19:1] adr = '0;
    logic [15:0] dat = '0;

    logic        cyc_w   [4];
    logic        ack_w   [4];
    logic        stall_w [4];
    logic [15:0] rdat_w  [4];

    int          ws [4] = '{3, 2, 0, 4};
    int          cur = 0;
    int          edge_cnt = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb [$];
    exp_t        mx;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sram_wb_emulator #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_dut0 (
        .clk_i(clk), .reset_i(reset_i), .cyc_i(cyc_w[0]), .stb_i(stb), .we_i(we), .sel_i(sel),
        .adr_i(adr), .dat_i(dat), .ack_o(ack_w[0]), .dat_o(rdat_w[0]), .stall_o(stall_w[0]));
    sram_wb_emulator #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_dut1 (
        .clk_i(clk), .reset_i(reset_i), .cyc_i(cyc_w[1]), .stb_i(stb), .we_i(we), .sel_i(sel),
        .adr_i(adr), .dat_i(dat), .ack_o(ack_w[1]), .dat_o(rdat_w[1]), .stall_o(stall_w[1]));
    sram_wb_emulator #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut2 (
        .clk_i(clk), .reset_i(reset_i), .cyc_i(cyc_w[2]), .stb_i(stb), .we_i(we), .sel_i(sel),
        .adr_i(adr), .dat_i(dat), .ack_o(ack_w[2]), .dat_o(rdat_w[2]), .stall_o(stall_w[2]));
    sram_wb_emulator #(.DEPTH_LOG2(10), .WAIT_STATES(4)) u_dut3 (
        .clk_i(clk), .reset_i(reset_i), .cyc_i(cyc_w[3]), .stb_i(stb), .we_i(we), .sel_i(sel),
        .adr_i(adr), .dat_i(dat), .ack_o(ack_w[3]), .dat_o(rdat_w[3]), .stall_o(stall_w[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation of the active responder.
    always @(negedge clk) begin
        if (!reset_i && ack_w[cur]) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'd1, 32'd0);
            end else begin
                mx = sb.pop_front();
                chk("ack_cycle", edge_cnt, mx.due);
                if (mx.rd) chk("read_data", {16'h0, rdat_w[cur]}, {16'h0, mx.d});
            end
        end
    end

    // Single request: drive, wait (bounded) for the ack, then check the stall count.
    task automatic xfer(input int k, input bit w, input logic [1:0] s, input logic [19:1] a,
                        input logic [15:0] d, input logic [15:0] e);
        exp_t x;
        int   stalls;
        bit   done;
        @(negedge clk);
        cur = k;
        chk("idle_stall", {31'h0, stall_w[k]}, 32'd0);
        cyc_w[k] = 1'b1;
        stb = 1'b1;
        we  = w;
        sel = s;
        adr = a;
        dat = d;
        x.rd = !w;
        x.d = e;
        x.due = edge_cnt + 1 + ws[k];
        sb.push_back(x);
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (sb.size() == 0) begin
                done = 1'b1;
            end else begin
                if (stall_w[k]) stalls++;
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("ack_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        chk("stall_cycles", stalls, ws[k]);
        cyc_w[k] = 1'b0;
    endtask

    // Wait (bounded) for all outstanding pipelined acks.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (sb.size() == 0) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            chk("drain_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t x;
        for (int k = 0; k < 4; k++) cyc_w[k] = 1'b0;

        // Reset state of every instance.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_ack", {31'h0, ack_w[k]}, 32'd0);
            chk("rst_stall", {31'h0, stall_w[k]}, 32'd0);
            chk("rst_dat", {16'h0, rdat_w[k]}, 32'd0);
        end
        reset_i = 1'b0;

        // Reset mid-wait, WAIT_STATES = 3.
        xfer(0, 1'b1, 2'b11, 19'h20, 16'h1111, 16'h0);
        xfer(0, 1'b0, 2'b11, 19'h20, 16'h0, 16'h1111);
        @(negedge clk);
        cur = 0;
        cyc_w[0] = 1'b1;
        stb = 1'b1;
        we  = 1'b1;
        sel = 2'b11;
        adr = 19'h20;
        dat = 16'h2222;
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
        chk("rw_wait_stall", {31'h0, stall_w[0]}, 32'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("rw_ack", {31'h0, ack_w[0]}, 32'd0);
        chk("rw_stall", {31'h0, stall_w[0]}, 32'd0);
        chk("rw_dat", {16'h0, rdat_w[0]}, 32'd0);
        cyc_w[0] = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        xfer(0, 1'b0, 2'b11, 19'h20, 16'h0, 16'h1111);

        // Basic write/read, WAIT_STATES = 2.
        xfer(1, 1'b1, 2'b11, 19'h10, 16'hA55A, 16'h0);
        xfer(1, 1'b0, 2'b11, 19'h10, 16'h0, 16'hA55A);
        repeat (3) @(negedge clk);
        chk("dat_hold", {16'h0, rdat_w[1]}, 32'h0000A55A);

        // Byte lanes.
        xfer(1, 1'b1, 2'b11, 19'h3, 16'hFFFF, 16'h0);
        xfer(1, 1'b1, 2'b10, 19'h3, 16'h1234, 16'h0);
        xfer(1, 1'b0, 2'b01, 19'h3, 16'h0, 16'h12FF);
        xfer(1, 1'b1, 2'b00, 19'h3, 16'hABCD, 16'h0);
        xfer(1, 1'b0, 2'b11, 19'h3, 16'h0, 16'h12FF);

        // Back-to-back, zero wait: 8 writes then 8 reads with stb held.
        @(negedge clk);
        cur = 2;
        cyc_w[2] = 1'b1;
        for (int n = 0; n < 16; n++) begin
            chk("zw_stall", {31'h0, stall_w[2]}, 32'd0);
            stb = 1'b1;
            we  = (n < 8);
            sel = 2'b11;
            adr = 19'(n % 8);
            dat = (n < 8) ? 16'(n) : 16'h0;
            x.rd = (n >= 8);
            x.d = 16'(n % 8);
            x.due = edge_cnt + 1;
            sb.push_back(x);
            @(negedge clk);
        end
        stb = 1'b0;
        we  = 1'b0;
        drain();
        chk("zw_stall_end", {31'h0, stall_w[2]}, 32'd0);
        cyc_w[2] = 1'b0;

        // Abort, WAIT_STATES = 4: cyc drops in cycle 2 of a write.
        xfer(3, 1'b1, 2'b11, 19'h5, 16'h5555, 16'h0);
        @(negedge clk);
        cur = 3;
        cyc_w[3] = 1'b1;
        stb = 1'b1;
        we  = 1'b1;
        sel = 2'b11;
        adr = 19'h5;
        dat = 16'h7777;
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
        chk("ab_stall", {31'h0, stall_w[3]}, 32'd1);
        @(negedge clk);
        cyc_w[3] = 1'b0;
        repeat (8) @(negedge clk);
        chk("ab_idle_stall", {31'h0, stall_w[3]}, 32'd0);
        chk("ab_no_ack", sb.size(), 32'd0);
        xfer(3, 1'b0, 2'b11, 19'h5, 16'h0, 16'h5555);

        // Aliasing: 0x405 and 0x005 share a word with 1K words.
        xfer(3, 1'b1, 2'b11, 19'h405, 16'hBEEF, 16'h0);
        xfer(3, 1'b0, 2'b11, 19'h5, 16'h0, 16'hBEEF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
